// File: rtl/cordic_iter_counter_pkg.sv
// Shared constants for the CORDIC iteration counter: state encoding,
// direction and mode values.
package cordic_counter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_WRAP    = 1'b1;

endpackage

// File: rtl/cordic_iter_counter_if.sv
// Control and status bundle between the CORDIC control FSM (master) and the
// iteration counter (slave).
interface cordic_iter_counter_if #(
  parameter int COUNTER_WIDTH = 5
);

  logic                     enable;
  logic                     start;
  logic                     abort;
  logic                     load;
  logic [COUNTER_WIDTH-1:0] load_value;
  logic [COUNTER_WIDTH-1:0] limit;
  logic                     dir;
  logic                     wrap;
  logic [COUNTER_WIDTH-1:0] c_output_W;
  logic                     busy;
  logic                     done;
  logic                     tc;

  modport master (
    output enable, start, abort, load, load_value, limit, dir, wrap,
    input  c_output_W, busy, done, tc
  );

  modport slave (
    input  enable, start, abort, load, load_value, limit, dir, wrap,
    output c_output_W, busy, done, tc
  );

endinterface

// File: rtl/cordic_iter_counter_step.sv
// Combinational step unit: next count in the requested direction and the
// flag telling whether the current count has reached the end value.
module cordic_count_step
  import cordic_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 5
) (
  input  logic [COUNTER_WIDTH-1:0] count_i,
  input  logic [COUNTER_WIDTH-1:0] limit_i,
  input  logic                     dir_i,
  output logic [COUNTER_WIDTH-1:0] next_o,
  output logic                     at_end_o
);

  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] end_val;

  // Step modulo 2^COUNTER_WIDTH; counting down ends at 0, up ends at limit.
  always_comb begin
    end_val  = (dir_i == DIR_DOWN) ? '0 : limit_i;
    next_o   = (dir_i == DIR_DOWN) ? (count_i - ONE) : (count_i + ONE);
    at_end_o = (count_i == end_val);
  end

endmodule

// File: rtl/cordic_iter_counter.sv
// CORDIC iteration counter: up/down counter with programmable terminal value,
// parallel load, one-shot or wrap mode, abort, and start/busy/done handshake.
module cordic_iter_counter
  import cordic_counter_pkg::*;
#(
  parameter int                       COUNTER_WIDTH = 5,
  parameter logic [COUNTER_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  cordic_iter_counter_if.slave  bus
);

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     tc_q, tc_d;

  logic [COUNTER_WIDTH-1:0] step_next;
  logic                     at_end;
  logic [COUNTER_WIDTH-1:0] start_val;

  // First value of a sequence; re-evaluated live so a wrap picks up a new limit.
  assign start_val = (bus.dir == DIR_DOWN) ? bus.limit : '0;

  cordic_count_step #(
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_step (
    .count_i  (count_q),
    .limit_i  (bus.limit),
    .dir_i    (bus.dir),
    .next_o   (step_next),
    .at_end_o (at_end)
  );

  // State, count and wrap-pulse registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; combinational blocks use blocking ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= RESET_VALUE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  // Next state and next count, priority abort > load > start > enable.
  // NOTE: every target gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // abort has nothing to terminate here; load still beats start.
        if (bus.load) begin
          count_d = bus.load_value;
        end else if (bus.start) begin
          count_d = start_val;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.load) begin
          count_d = bus.load_value;
        end else if (bus.enable) begin
          if (at_end) begin
            if (bus.wrap == MODE_WRAP) begin
              count_d = start_val;
              tc_d    = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            count_d = step_next;
          end
        end
      end
      ST_DONE: begin
        if (bus.load) begin
          count_d = bus.load_value;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded purely from registers, so they are glitch-free.
  always_comb begin
    bus.c_output_W = count_q;
    bus.busy       = (state_q == ST_RUN);
    bus.done       = (state_q == ST_DONE);
    bus.tc         = tc_q;
  end

endmodule

// File: tb/tb_cordic_iter_counter.sv
// Self-checking bench for cordic_iter_counter: directed scenarios plus
// randomized traffic, all compared against a behavioural model.
module tb_cordic_iter_counter;

  localparam int W   = 5;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_e;
  mstate_e m_state;
  int      m_count;
  bit      m_tc;
  int      tc_seen   = 0;
  int      done_seen = 0;

  always #5 clk = ~clk;

  cordic_iter_counter_if #(.COUNTER_WIDTH(W)) bus ();

  cordic_iter_counter #(
    .COUNTER_WIDTH (W),
    .RESET_VALUE   ('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = M_IDLE;
    m_count = 0;
    m_tc    = 1'b0;
  endfunction

  // Behavioural model of one clock edge, evaluated on the inputs present at that edge.
  function automatic void model_step();
    int start_v = bus.dir ? int'(bus.limit) : 0;
    int end_v   = bus.dir ? 0 : int'(bus.limit);
    m_tc = 1'b0;
    case (m_state)
      M_IDLE: begin
        if (bus.load) m_count = int'(bus.load_value);
        else if (bus.start) begin
          m_count = start_v;
          m_state = M_RUN;
        end
      end
      M_RUN: begin
        if (bus.abort) m_state = M_IDLE;
        else if (bus.load) m_count = int'(bus.load_value);
        else if (bus.enable) begin
          if (m_count == end_v) begin
            if (bus.wrap) begin
              m_count = start_v;
              m_tc    = 1'b1;
            end else begin
              m_state = M_DONE;
            end
          end else begin
            m_count = (m_count + (bus.dir ? MOD - 1 : 1)) % MOD;
          end
        end
      end
      default: begin
        if (bus.load) m_count = int'(bus.load_value);
        m_state = M_IDLE;
      end
    endcase
  endfunction

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, ":count"}, 32'(bus.c_output_W), 32'(m_count));
    check({tag, ":busy"},  32'(bus.busy), 32'(m_state == M_RUN));
    check({tag, ":done"},  32'(bus.done), 32'(m_state == M_DONE));
    check({tag, ":tc"},    32'(bus.tc),   32'(m_tc));
    if (bus.tc === 1'b1)   tc_seen++;
    if (bus.done === 1'b1) done_seen++;
  endtask

  task automatic quiet_inputs();
    bus.enable = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.load   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int d0;
    bit hit;

    rst = 1'b1;
    quiet_inputs();
    bus.load_value = '0;
    bus.limit      = '0;
    bus.dir        = 1'b0;
    bus.wrap       = 1'b0;
    model_reset();
    #12;
    check("reset:count", 32'(bus.c_output_W), 32'd0);
    check("reset:busy",  32'(bus.busy), 32'd0);
    check("reset:done",  32'(bus.done), 32'd0);
    check("reset:tc",    32'(bus.tc),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-count: asynchronous, no clock edge needed.
    bus.limit = 5'd7;
    bus.start = 1'b1;
    tick("rstmid_start");
    bus.start  = 1'b0;
    bus.enable = 1'b1;
    d0 = done_seen;
    repeat (3) tick("rstmid_run");
    check("rstmid:count_before", 32'(bus.c_output_W), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rstmid:count", 32'(bus.c_output_W), 32'd0);
    check("rstmid:busy",  32'(bus.busy), 32'd0);
    check("rstmid:done",  32'(bus.done), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.enable = 1'b0;
    tick("rstmid_idle");
    check("rstmid:no_done", 32'(done_seen - d0), 32'd0);

    // One-shot up, limit 4, continuous enable.
    bus.limit = 5'd4;
    bus.start = 1'b1;
    tick("up_start");
    check("up:first", 32'(bus.c_output_W), 32'd0);
    bus.start  = 1'b0;
    bus.enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick("up_run");
      check("up:seq", 32'(bus.c_output_W), 32'(i));
    end
    tick("up_end");
    check("up:done", 32'(bus.done), 32'd1);
    check("up:hold", 32'(bus.c_output_W), 32'd4);
    tick("up_idle");
    check("up:idle_busy", 32'(bus.busy), 32'd0);
    check("up:idle_done", 32'(bus.done), 32'd0);
    bus.enable = 1'b0;

    // One-shot down with gapped enable.
    bus.dir   = 1'b1;
    bus.limit = 5'd3;
    bus.start = 1'b1;
    tick("down_start");
    check("down:first", 32'(bus.c_output_W), 32'd3);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      bus.enable = (i % 2 == 0);
      tick("down_run");
      if (bus.done === 1'b1) hit = 1'b1;
    end
    check("down:done_reached", 32'(hit), 32'd1);
    check("down:end_count", 32'(bus.c_output_W), 32'd0);
    bus.enable = 1'b0;
    tick("down_idle");

    // Wrap mode: tc twice in 7 enabled edges, never done.
    bus.dir   = 1'b0;
    bus.wrap  = 1'b1;
    bus.limit = 5'd2;
    bus.start = 1'b1;
    tick("wrap_start");
    bus.start  = 1'b0;
    bus.enable = 1'b1;
    t0 = tc_seen;
    d0 = done_seen;
    repeat (7) tick("wrap_run");
    check("wrap:tc_pulses", 32'(tc_seen - t0), 32'd2);
    check("wrap:no_done", 32'(done_seen - d0), 32'd0);
    check("wrap:busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick("wrap_abort");
    quiet_inputs();
    bus.wrap = 1'b0;

    // Load beyond limit while counting up: wraps through 2^W to reach limit.
    bus.limit = 5'd5;
    bus.start = 1'b1;
    tick("ld_start");
    bus.start      = 1'b0;
    bus.load       = 1'b1;
    bus.load_value = 5'd30;
    tick("ld_load");
    check("ld:loaded", 32'(bus.c_output_W), 32'd30);
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      tick("ld_run");
      if (bus.done === 1'b1) hit = 1'b1;
    end
    check("ld:done_reached", 32'(hit), 32'd1);
    check("ld:end_count", 32'(bus.c_output_W), 32'd5);
    bus.enable = 1'b0;
    tick("ld_idle");

    // Priority: abort beats load and start in RUN.
    bus.start = 1'b1;
    tick("pri_start");
    bus.start  = 1'b0;
    bus.enable = 1'b1;
    repeat (2) tick("pri_run");
    bus.enable     = 1'b0;
    bus.start      = 1'b1;
    bus.load       = 1'b1;
    bus.abort      = 1'b1;
    bus.load_value = 5'd9;
    tick("pri_abort");
    check("pri:abort_busy", 32'(bus.busy), 32'd0);
    check("pri:abort_count", 32'(bus.c_output_W), 32'd2);
    // In IDLE load beats start.
    bus.abort      = 1'b0;
    bus.load_value = 5'd17;
    tick("pri_idle_load");
    check("pri:idle_load", 32'(bus.c_output_W), 32'd17);
    check("pri:idle_busy", 32'(bus.busy), 32'd0);
    // limit 0 finishes on the first enabled edge.
    bus.load  = 1'b0;
    bus.limit = 5'd0;
    tick("lim0_start");
    bus.start  = 1'b0;
    bus.enable = 1'b1;
    tick("lim0_run");
    check("lim0:done", 32'(bus.done), 32'd1);
    quiet_inputs();
    tick("lim0_idle");

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      bus.enable = ($urandom_range(0, 99) < 70);
      bus.start  = ($urandom_range(0, 99) < 20);
      bus.abort  = ($urandom_range(0, 99) < 3);
      bus.load   = ($urandom_range(0, 99) < 5);
      bus.load_value = 5'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 99) < 8)
        bus.limit = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, MOD - 1))
                                                : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 5) bus.dir  = ~bus.dir;
      if ($urandom_range(0, 99) < 4) bus.wrap = ~bus.wrap;
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
